// File: rtl/dmem_axi_slave.sv
// AXI4-Lite slave data memory: one transaction at a time, reads first,
// AW/W in any order, word RAM with byte-lane writes.
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   axi_ar*/axi_r*        read address / read data channels
//   axi_aw*/axi_w*/axi_b* write address / data / response channels
//   axi_arprot/awprot     accepted and ignored
//
// Build option: define DMEM_RANGE_CHECK_EN to answer addresses outside
// [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2) with SLVERR and no RAM access.
// Without it, addresses alias modulo the RAM size and responses are OKAY.

module dmem_axi_slave #(
  parameter int          DEPTH_LOG2 = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  input  logic [2:0]  axi_arprot,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [2:0]  axi_awprot,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE,
    R_WAIT,
    R_RESP,
    W_COLLECT,
    W_COMMIT,
    W_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]           r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_err;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_aw_got;
  logic                  r_w_got;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rvalid;
  logic [1:0]            r_bresp;
  logic                  r_bvalid;

  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_err;
  logic w_aw_err;
  logic w_mem_we;
  logic w_unused;

`ifdef DMEM_RANGE_CHECK_EN
  // 33-bit bounds so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + (33'd4 << DEPTH_LOG2);

  function automatic logic f_oob(input logic [31:0] a);
    return ({1'b0, a} < LO) || ({1'b0, a} >= HI);
  endfunction

  assign w_ar_err = f_oob(axi_araddr);
  assign w_aw_err = f_oob(axi_awaddr);
`else
  assign w_ar_err = 1'b0;
  assign w_aw_err = 1'b0;
`endif

  // Protection bits, the address bits outside the word index and the
  // base address (range-check builds only) carry no function here.
  assign w_unused = ^{axi_arprot, axi_awprot,
                      axi_araddr, axi_awaddr, BASE_ADDR};

  assign w_ar_hs = axi_arvalid & axi_arready;
  assign w_aw_hs = axi_awvalid & axi_awready;
  assign w_w_hs  = axi_wvalid & axi_wready;

  assign axi_rdata  = r_rdata;
  assign axi_rresp  = r_rresp;
  assign axi_rvalid = r_rvalid;
  assign axi_bresp  = r_bresp;
  assign axi_bvalid = r_bvalid;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state and readies. A pending read in IDLE masks the write
  // channels so that the read always wins.
  always_comb begin
    w_next      = r_state;
    axi_arready = 1'b0;
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    unique case (r_state)
      IDLE: begin
        axi_arready = 1'b1;
        axi_awready = !axi_arvalid;
        axi_wready  = !axi_arvalid;
        if (axi_arvalid)
          w_next = R_WAIT;
        else if (axi_awvalid && axi_wvalid)
          w_next = W_COMMIT;
        else if (axi_awvalid || axi_wvalid)
          w_next = W_COLLECT;
      end
      R_WAIT: w_next = R_RESP;
      R_RESP: begin
        if (axi_rready) w_next = IDLE;
      end
      W_COLLECT: begin
        axi_awready = !r_aw_got;
        axi_wready  = !r_w_got;
        if ((r_aw_got || axi_awvalid) &&
            (r_w_got || axi_wvalid))
          w_next = W_COMMIT;
      end
      W_COMMIT: w_next = W_RESP;
      W_RESP: begin
        if (axi_bready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (!rstn) begin
      axi_arready = 1'b0;
      axi_awready = 1'b0;
      axi_wready  = 1'b0;
    end
  end

  // Reads and writes share r_idx/r_err: only one transaction is live.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rvalid <= 1'b0;
      r_bvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_bresp  <= '0;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, W_COLLECT: begin
          if (w_ar_hs) begin
            r_idx <= axi_araddr[DEPTH_LOG2+1:2];
            r_err <= w_ar_err;
          end else begin
            if (w_aw_hs) begin
              r_idx    <= axi_awaddr[DEPTH_LOG2+1:2];
              r_err    <= w_aw_err;
              r_aw_got <= 1'b1;
            end
            if (w_w_hs) begin
              r_wdata <= axi_wdata;
              r_wstrb <= axi_wstrb;
              r_w_got <= 1'b1;
            end
          end
        end
        R_WAIT: begin
          r_rvalid <= 1'b1;
          r_rdata  <= r_err ? 32'h0 : r_mem[r_idx];
          r_rresp  <= r_err ? 2'b10 : 2'b00;
        end
        R_RESP: begin
          if (axi_rready) r_rvalid <= 1'b0;
        end
        W_COMMIT: begin
          r_bvalid <= 1'b1;
          r_bresp  <= r_err ? 2'b10 : 2'b00;
        end
        W_RESP: begin
          if (axi_bready) begin
            r_bvalid <= 1'b0;
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset on the commit edge suppresses the write.
  assign w_mem_we = rstn && (r_state == W_COMMIT) && !r_err;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i])
          r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_axi_slave.sv
// Scoreboard bench for dmem_axi_slave: expected R/B responses queued at
// issue, compared by a monitor when the handshake is seen.

module tb_dmem_axi_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] axi_araddr = '0;
  logic        axi_arvalid = 1'b0;
  logic        axi_arready;
  logic [2:0]  axi_arprot = '0;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready = 1'b1;
  logic [31:0] axi_awaddr = '0;
  logic        axi_awvalid = 1'b0;
  logic        axi_awready;
  logic [2:0]  axi_awprot = '0;
  logic [31:0] axi_wdata = '0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_wvalid = 1'b0;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready = 1'b1;

  int n_chk = 0;
  int n_fail = 0;

  logic [33:0] rq[$];
  logic [1:0]  bq[$];
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  dmem_axi_slave #(
    .DEPTH_LOG2(14),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .axi_araddr (axi_araddr),
    .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_arprot (axi_arprot),
    .axi_rdata  (axi_rdata),
    .axi_rresp  (axi_rresp),
    .axi_rvalid (axi_rvalid),
    .axi_rready (axi_rready),
    .axi_awaddr (axi_awaddr),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_awprot (axi_awprot),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_bresp  (axi_bresp),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit oob(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a >= 32'h0001_0000;
`else
    return (a === 32'hxxxx_xxxx);
`endif
  endfunction

  function automatic logic [33:0] rd_exp(input logic [31:0] a);
    int k;
    k = int'(a[15:2]);
    if (oob(a)) return {2'b10, 32'h0};
    if (mdl.exists(k)) return {2'b00, mdl[k]};
    return {2'b00, 32'h0};
  endfunction

  task automatic mdl_wr(input logic [31:0] a, d,
                        input logic [3:0] s);
    int k;
    logic [31:0] v;
    k = int'(a[15:2]);
    if (!oob(a)) begin
      v = mdl.exists(k) ? mdl[k] : 32'h0;
      for (int i = 0; i < 4; i++)
        if (s[i]) v[8*i +: 8] = d[8*i +: 8];
      mdl[k] = v;
    end
  endtask

  always @(negedge clk) begin
    logic [33:0] er;
    logic [1:0]  eb;
    if (rstn === 1'b1 && axi_rvalid && axi_rready) begin
      if (rq.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        er = rq.pop_front();
        chk("rdata", {axi_rresp, axi_rdata}, er);
      end
    end
    if (rstn === 1'b1 && axi_bvalid && axi_bready) begin
      if (bq.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        eb = bq.pop_front();
        chk("bresp", axi_bresp, eb);
      end
    end
  end

  // Ends #1 after the AR handshake edge.
  task automatic issue_ar(input logic [31:0] a);
    int n;
    bit hs;
    n = 0;
    hs = 0;
    @(posedge clk); #1;
    axi_araddr  = a;
    axi_arvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = axi_arready;
      @(posedge clk); #1;
      n++;
    end
    axi_arvalid = 1'b0;
    if (!hs) chk("ar_timeout", 0, 1);
  endtask

  // Edges counted with the handshake edge as 1; ends at the negedge
  // where valid is first seen.
  task automatic wait_v(input bit is_b, output int lat);
    bit got;
    got = 0;
    lat = 1;
    while (!got && lat < 20) begin
      @(negedge clk);
      if (is_b ? axi_bvalid : axi_rvalid) got = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic wait_drop(input bit is_b);
    int n;
    n = 0;
    while ((is_b ? axi_bvalid : axi_rvalid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (is_b ? axi_bvalid : axi_rvalid)
      chk(is_b ? "b_drop" : "r_drop", 1, 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    logic [33:0] e;
    int lat;
    e = rd_exp(a);
    rq.push_back(e);
    axi_rready = (hold == 0);
    issue_ar(a);
    wait_v(0, lat);
    chk("rd_latency", lat, 2);
    for (int i = 0; i < hold; i++) begin
      chk("rhold", {axi_rvalid, axi_rresp, axi_rdata}, {1'b1, e});
      @(posedge clk); #1;
    end
    axi_rready = 1'b1;
    wait_drop(0);
  endtask

  task automatic do_write(input logic [31:0] a, d,
                          input logic [3:0] s,
                          input int lead, input int hold);
    int cyc, w_cyc, aw_cyc, lat;
    bit awf, wf;
    logic [1:0] e;
    e = oob(a) ? 2'b10 : 2'b00;
    bq.push_back(e);
    mdl_wr(a, d, s);
    axi_bready = (hold == 0);
    cyc = 0;
    w_cyc = -1;
    aw_cyc = -1;
    @(posedge clk); #1;
    axi_awaddr  = a;
    axi_wdata   = d;
    axi_wstrb   = s;
    axi_wvalid  = 1'b1;
    axi_awvalid = (lead == 0);
    while ((w_cyc < 0 || aw_cyc < 0) && cyc < 50) begin
      @(negedge clk);
      awf = axi_awvalid & axi_awready;
      wf  = axi_wvalid & axi_wready;
      @(posedge clk); #1;
      cyc++;
      if (wf) begin axi_wvalid = 1'b0; w_cyc = cyc; end
      if (awf) begin axi_awvalid = 1'b0; aw_cyc = cyc; end
      if (aw_cyc < 0 && cyc == lead) axi_awvalid = 1'b1;
    end
    axi_wvalid  = 1'b0;
    axi_awvalid = 1'b0;
    chk("w_hs_cycle", w_cyc, 1);
    chk("aw_hs_cycle", aw_cyc, lead + 1);
    wait_v(1, lat);
    chk("wr_latency", lat, 2);
    for (int i = 0; i < hold; i++) begin
      chk("bhold", {axi_bvalid, axi_bresp}, {1'b1, e});
      @(posedge clk); #1;
    end
    axi_bready = 1'b1;
    wait_drop(1);
  endtask

  task automatic prio_test();
    int cyc, rd_done, aw_cyc, w_cyc, viol, lat;
    bit seen_rv, arf, awf, wf;
    rq.push_back(rd_exp(32'h10));
    mdl_wr(32'h14, 32'hCAFE_F00D, 4'hF);
    bq.push_back(2'b00);
    cyc = 0; rd_done = -1; aw_cyc = -1; w_cyc = -1;
    viol = 0; seen_rv = 0;
    @(posedge clk); #1;
    axi_araddr  = 32'h10;
    axi_awaddr  = 32'h14;
    axi_wdata   = 32'hCAFE_F00D;
    axi_wstrb   = 4'hF;
    axi_arvalid = 1'b1;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    while ((aw_cyc < 0 || w_cyc < 0) && cyc < 60) begin
      @(negedge clk);
      if (axi_rvalid) seen_rv = 1;
      if (seen_rv && !axi_rvalid && rd_done < 0) rd_done = cyc;
      if (rd_done < 0 && (axi_awready || axi_wready)) viol++;
      arf = axi_arvalid & axi_arready;
      awf = axi_awvalid & axi_awready;
      wf  = axi_wvalid & axi_wready;
      @(posedge clk); #1;
      cyc++;
      if (arf) axi_arvalid = 1'b0;
      if (awf) begin axi_awvalid = 1'b0; aw_cyc = cyc; end
      if (wf) begin axi_wvalid = 1'b0; w_cyc = cyc; end
    end
    axi_arvalid = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    chk("prio_ready_low", viol, 0);
    chk("prio_read_done", rd_done >= 0, 1);
    chk("prio_aw_after_r", aw_cyc > rd_done, 1);
    chk("prio_w_with_aw", w_cyc, aw_cyc);
    wait_v(1, lat);
    chk("prio_wr_latency", lat, 2);
    wait_drop(1);
  endtask

  task automatic reset_in_rresp();
    int lat;
    axi_rready = 1'b0;
    issue_ar(32'h10);
    wait_v(0, lat);
    chk("rst_pre_rvalid", axi_rvalid, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_ready_forced",
        {axi_arready, axi_awready, axi_wready}, 3'b000);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_rvalid_drop", axi_rvalid, 0);
    chk("rst_idle_arready", axi_arready, 1);
    axi_rready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    axi_arvalid = 1'b1;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_resp", {axi_rresp, axi_bresp}, 4'b0000);
    chk("rst_readies",
        {axi_arready, axi_awready, axi_wready}, 3'b000);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    rstn        = 1'b1;

    do_write(32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 0);
    do_read(32'h10, 0);
    do_write(32'h10, 32'h00AB_0000, 4'b0100, 0, 0);
    do_read(32'h10, 0);
    do_write(32'h10, 32'hFFFF_FFFF, 4'b0000, 0, 0);
    do_read(32'h10, 0);
    do_write(32'h20, 32'h1234_5678, 4'b1111, 3, 0);
    do_read(32'h20, 0);
    prio_test();
    do_read(32'h14, 0);
    do_read(32'h20, 5);
    do_write(32'h24, 32'hA5A5_5A5A, 4'b1111, 0, 5);
    do_write(32'h24, 32'h0000_C300, 4'b0010, 1, 0);
    do_read(32'h24, 0);
    reset_in_rresp();
    do_read(32'h10, 0);
`ifdef DMEM_RANGE_CHECK_EN
    do_write(32'h0, 32'h1122_3344, 4'b1111, 0, 0);
    do_write(32'h0001_0000, 32'hFFFF_FFFF, 4'b1111, 0, 0);
    do_read(32'h0, 0);
    do_read(32'h0001_0000, 0);
`else
    rq.push_back({2'b00, mdl[4]});
    issue_ar(32'h0001_0010);
    begin
      int lat;
      wait_v(0, lat);
      chk("alias_latency", lat, 2);
    end
    wait_drop(0);
`endif
    repeat (3) @(posedge clk);
    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
